// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray-conversion scheduler: result FSM states
// and default sizing constants.
package gray_conv_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage : gray_conv_pkg

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder.
//   bin  : binary word in
//   gray : Gray code of bin (g[W-1]=b[W-1], g[i]=b[i+1]^b[i])
module gray_enc #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule : gray_enc

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one binary-to-Gray datapath among N_REQ
// requesters; the result is registered with the granted requester ID.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_data  per-requester valid and packed binary words
//   req_ready           one-hot combinational grant
//   out_valid/out_ready result handshake
//   out_bin/out_gray    registered granted word and its Gray code
//   out_id              index of the granted requester
//   err                 sticky Gray/binary consistency failure
//
// Optional build: define GRAY_CONV_SCHED_CHECK_EN to add an inverse decode
// of out_gray compared against out_bin; otherwise err is tied low.
module gray_conv_sched
    import gray_conv_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_bin,
    output logic [WIDTH-1:0]       out_gray,
    output logic [ID_W-1:0]        out_id,
    output logic                   err
);

    state_e            state_q;
    state_e            state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [WIDTH-1:0]  out_bin_q;
    logic [WIDTH-1:0]  out_gray_q;
    logic [ID_W-1:0]   out_id_q;

    logic              can_load;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  gnt_data;
    logic [WIDTH-1:0]  gnt_gray;
    int unsigned       search_idx;

    // Loading is allowed into an empty register or when the current result
    // leaves this cycle; held off entirely while reset is asserted.
    assign can_load = rst_n & ((state_q == ST_EMPTY) | out_ready);

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin : arb_search
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        req_ready  = '0;
        search_idx = 0;
        if (can_load) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                search_idx = 32'(rr_ptr_q) + k;
                if (search_idx >= N_REQ) begin
                    search_idx = search_idx - N_REQ;
                end
                if (!gnt_found && req_valid[ID_W'(search_idx)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = ID_W'(search_idx);
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Select the granted requester's word.
    always_comb begin : data_mux
        gnt_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                gnt_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .bin  (gnt_data),
        .gray (gnt_gray)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next pointer.
    always_comb begin : state_next
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (gnt_found) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (gnt_found) begin
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Result register and round-robin pointer; both move only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin : result_reg
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            out_bin_q  <= '0;
            out_gray_q <= '0;
            out_id_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (gnt_found) begin
                out_bin_q  <= gnt_data;
                out_gray_q <= gnt_gray;
                out_id_q   <= gnt_idx;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_bin   = out_bin_q;
    assign out_gray  = out_gray_q;
    assign out_id    = out_id_q;

`ifdef GRAY_CONV_SCHED_CHECK_EN
    logic [WIDTH-1:0] chk_bin;
    logic             chk_acc;
    logic             err_q;

    // Inverse Gray decode: running XOR from the MSB down.
    always_comb begin : gray_dec
        chk_bin = '0;
        chk_acc = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            chk_acc    = chk_acc ^ out_gray_q[i];
            chk_bin[i] = chk_acc;
        end
    end

    // Sticky mismatch flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin : err_reg
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (out_valid && (chk_bin != out_bin_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule : gray_conv_sched

// File: tb/tb_gray_conv_sched.sv
// Self-checking bench for gray_conv_sched: a reference round-robin model
// pushes expected results on every grant; they are popped and compared as
// the DUT presents them, plus directed checks on the scenarios of interest.
module tb_gray_conv_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_bin;
    logic [W-1:0]   out_gray;
    logic [1:0]     out_id;
    logic           err;

    gray_conv_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_gray  (out_gray),
        .out_id    (out_id),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] bin;
        logic [3:0] gray;
    } res_t;

    res_t sb[$];
    int   glog[$];
    int   olog_gray[$];
    int   olog_cyc[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en;
    bit   m_full;
    int   m_ptr;
    bit   m_found;
    int   m_gi;
    int   m_j;
    logic [N-1:0] m_rdy;
    logic [3:0]   m_bin;
    res_t         m_item;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
        req_valid = v;
        req_data  = {d3, d2, d1, d0};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb.delete();
        end else if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_full));
            if (m_full && sb.size() > 0) begin
                chk("out_id",   32'(out_id),   32'(sb[0].id));
                chk("out_bin",  32'(out_bin),  32'(sb[0].bin));
                chk("out_gray", 32'(out_gray), 32'(sb[0].gray));
            end
            chk("err", 32'(err), 32'(0));
            m_found = 1'b0;
            m_gi    = 0;
            m_rdy   = '0;
            if (!m_full || out_ready) begin
                for (int k = 0; k < N; k++) begin
                    m_j = (m_ptr + k) % N;
                    if (!m_found && req_valid[m_j]) begin
                        m_found = 1'b1;
                        m_gi    = m_j;
                    end
                end
            end
            if (m_found) m_rdy[m_gi] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(m_rdy));
            if (m_full && out_ready && sb.size() > 0) begin
                olog_gray.push_back(int'(sb[0].gray));
                olog_cyc.push_back(cyc);
                void'(sb.pop_front());
            end
            if (m_found) begin
                m_bin       = req_data[m_gi*W +: W];
                m_item.id   = m_gi;
                m_item.bin  = m_bin;
                m_item.gray = to_gray(m_bin);
                sb.push_back(m_item);
                glog.push_back(m_gi);
                m_ptr  = (m_gi + 1) % N;
                m_full = 1'b1;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    logic [3:0] saved_gray;
    logic [3:0] held_bin;

    initial begin
        mon_en    = 1'b1;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        set_req(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4);

        // Reset state, with requesters valid to exercise grant gating.
        #3;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_bin",   32'(out_bin),   32'(0));
        chk("rst_gray",  32'(out_gray),  32'(0));
        chk("rst_id",    32'(out_id),    32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_err",   32'(err),       32'(0));
        set_req(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Single request.
        out_ready = 1'b1;
        set_req(4'b0001, 4'b0100, 4'h0, 4'h0, 4'h0);
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        step(1);
        req_valid = '0;
        #1;
        chk("single_valid", 32'(out_valid), 32'(1));
        chk("single_gray",  32'(out_gray),  32'b0110);
        chk("single_bin",   32'(out_bin),   32'b0100);
        chk("single_id",    32'(out_id),    32'(0));
        step(2);

        // Fairness from a fresh pointer.
        apply_reset();
        glog.delete(); olog_gray.delete(); olog_cyc.delete();
        set_req(4'b1111, 4'b0001, 4'b1001, 4'b0011, 4'b1101);
        step(4);
        req_valid = '0;
        step(1);
        chk("fair_n", 32'(glog.size()), 32'(4));
        chk("fair_out_n", 32'(olog_gray.size()), 32'(4));
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("fair_order", 32'(glog[i]), 32'(i));
        end
        if (olog_gray.size() == 4) begin
            chk("fair_g0", 32'(olog_gray[0]), 32'b0001);
            chk("fair_g1", 32'(olog_gray[1]), 32'b1101);
            chk("fair_g2", 32'(olog_gray[2]), 32'b0010);
            chk("fair_g3", 32'(olog_gray[3]), 32'b1011);
            for (int i = 1; i < 4; i++)
                chk("fair_gap", 32'(olog_cyc[i] - olog_cyc[i-1]), 32'(1));
        end

        // Backpressure: hold a result while requesters 1 and 2 wait.
        out_ready = 1'b0;
        set_req(4'b0001, 4'h5, 4'h6, 4'h7, 4'h0);
        step(1);
        set_req(4'b0110, 4'h5, 4'h6, 4'h7, 4'h0);
        held_bin = out_bin;
        chk("bp_held_bin", 32'(held_bin), 32'h5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'(0));
            chk("bp_stable", 32'(out_bin), 32'(held_bin));
            step(1);
        end
        glog.delete();
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        step(1);
        req_valid = '0;
        #1;
        chk("bp_next_id", 32'(out_id), 32'(1));
        chk("bp_next_bin", 32'(out_bin), 32'h6);
        step(2);

        // Pointer wrap.
        glog.delete();
        set_req(4'b1000, 4'hA, 4'h0, 4'h0, 4'hB);
        step(1);
        set_req(4'b1001, 4'hA, 4'h0, 4'h0, 4'hB);
        step(2);
        req_valid = '0;
        step(1);
        chk("wrap_n", 32'(glog.size()), 32'(3));
        if (glog.size() == 3) begin
            chk("wrap_0", 32'(glog[0]), 32'(3));
            chk("wrap_1", 32'(glog[1]), 32'(0));
            chk("wrap_2", 32'(glog[2]), 32'(3));
        end

        // Reset mid-stream while FULL.
        out_ready = 1'b0;
        set_req(4'b0010, 4'h0, 4'hF, 4'h0, 4'h0);
        step(1);
        chk("mid_full", 32'(out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'(0));
        chk("mid_bin",   32'(out_bin),   32'(0));
        chk("mid_gray",  32'(out_gray),  32'(0));
        chk("mid_id",    32'(out_id),    32'(0));
        chk("mid_ready", 32'(req_ready), 32'(0));
        step(1);
        glog.delete();
        out_ready = 1'b1;
        set_req(4'b1100, 4'h0, 4'h0, 4'h9, 4'h3);
        rst_n = 1'b1;
        #1;
        chk("mid_first_ready", 32'(req_ready), 32'b0100);
        step(1);
        req_valid = '0;
        step(1);
        if (glog.size() > 0) chk("mid_first_gnt", 32'(glog[0]), 32'(2));
        else chk("mid_first_gnt", 32'(-1), 32'(2));

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            set_req(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step(1);
        end
        req_valid = '0;
        out_ready = 1'b1;
        step(2);
        chk("drain_empty", 32'(sb.size()), 32'(0));

`ifdef GRAY_CONV_SCHED_CHECK_EN
        // Corrupt the held Gray word and expect the sticky error.
        out_ready = 1'b0;
        set_req(4'b0001, 4'h7, 4'h0, 4'h0, 4'h0);
        step(1);
        req_valid = '0;
        mon_en = 1'b0;
        #1;
        chk("err_clean", 32'(err), 32'(0));
        saved_gray = out_gray;
        force dut.out_gray_q = saved_gray ^ 4'b0001;
        #1;
        chk("err_pre_edge", 32'(err), 32'(0));
        step(1);
        chk("err_set", 32'(err), 32'(1));
        release dut.out_gray_q;
        step(2);
        chk("err_sticky", 32'(err), 32'(1));
        apply_reset();
        #1;
        chk("err_cleared", 32'(err), 32'(0));
        mon_en = 1'b1;
        out_ready = 1'b1;
        set_req(4'b0011, 4'h3, 4'hC, 4'h0, 4'h0);
        step(4);
        req_valid = '0;
        step(2);
`else
        saved_gray = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_gray_conv_sched

// File: doc/gray_conv_sched.md
# gray_conv_sched

Round-robin scheduler that shares a single 4-bit binary-to-Gray conversion datapath among several requesters. Each requester presents a binary word with a valid/ready handshake. The block grants one requester per cycle and registers the Gray result together with the requester ID. The result is presented on a single valid/ready output port. It sits between multiple pointer/counter sources (e.g. FIFO write/read pointer logic) and the consumers of their Gray-coded values.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `WIDTH`, default 4: data width of the binary and Gray words.
- `ID_W`, default `$clog2(N_REQ)`: requester ID width, derived; do not override.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  `N_REQ`  per-requester valid.
- `req_data`  in  `N_REQ*WIDTH`  binary words; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  `N_REQ`  one-hot grant; the transfer for requester i occurs when `req_valid[i] & req_ready[i]`.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `out_bin`  out  `WIDTH`  binary word that was granted, registered.
- `out_gray`  out  `WIDTH`  Gray code of `out_bin`: `g[W-1]=b[W-1]`, `g[i]=b[i+1]^b[i]`.
- `out_id`  out  `ID_W`  index of the granted requester.
- `err`  out  1  sticky check-failure flag; see Configuration.

## Operation
- Two-state FSM on the result register:
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
- Grant eligibility: `can_load = (state==EMPTY) | out_ready`.
- Arbitration:
  - When `can_load` is true, grant the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap modulo `N_REQ`.
  - `req_ready` is one-hot on that requester and combinational from `req_valid`, `rr_ptr` and the state.
  - `req_ready` is all zero when `can_load=0` or when no requester is valid.
- On a grant:
  - Load `out_bin`, `out_gray` and `out_id`.
  - Set `rr_ptr` to (granted index + 1) mod `N_REQ`.
  - Next state is FULL.
- Transitions:
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on `out_ready` with no grant.
  - FULL -> FULL on `out_ready` with a grant (back-to-back load).
  - FULL -> FULL with no `out_ready`; the output is held.
- While FULL and `out_ready=0`, `out_bin`, `out_gray` and `out_id` must not change.
- Requester data is not held internally. A requester that is not granted keeps `req_valid` asserted and its data stable.
- `rr_ptr` changes only on a grant.

## Timing
- Latency: a grant in cycle N produces the result with `out_valid=1` in cycle N+1.
- Throughput: one result per cycle while `out_ready=1`.
- Reset values:
  - state EMPTY, `out_valid=0`.
  - `out_bin`, `out_gray`, `out_id` = 0.
  - `rr_ptr` = 0.
  - `err` = 0.
  - `req_ready` = 0.
- Reset asserted mid-operation:
  - All registers clear immediately, asynchronously.
  - A pending result is dropped.
  - The first grant after deassertion goes to the lowest-index valid requester.
- Simultaneous consume and grant in the same cycle: the old result is accepted and the new result is loaded; no bubble.
- With a single valid requester, that requester is granted every eligible cycle; there is no fairness penalty.

## Configuration
- Macro: `GRAY_CONV_SCHED_CHECK_EN`.
- Defined:
  - Instantiate an inverse Gray-to-binary decode of the registered `out_gray`: `b[W-1]=g[W-1]`, `b[i]=b[i+1]^g[i]`.
  - While `out_valid=1`, compare the decoded value with `out_bin`.
  - On mismatch, set `err` at the next edge; `err` then stays set until reset.
- Undefined: `err` is tied to 0 and no decode logic is built.

## Structure
- Shared package `gray_conv_pkg`:
  - FSM state enum `{ST_EMPTY, ST_FULL}`.
  - Default `N_REQ` and `WIDTH` constants.
- Sub-module `gray_enc`: a parameterised `WIDTH` combinational binary-to-Gray encoder. It is instantiated once, on the granted data before the result register.
- The round-robin search stays inline in the top module.

## Test plan
- Single request: `req_valid=0001`, `req_data[0]=0100`, `out_ready=1` -> `req_ready=0001` in the same cycle; next cycle `out_valid=1`, `out_gray=0110`, `out_bin=0100`, `out_id=0`.
- Fairness: all four valid with data 0001, 1001, 0011, 1101, `out_ready=1` -> grant order 0,1,2,3; `out_gray` sequence 0001, 1101, 0010, 1011 on consecutive cycles; no gaps.
- Backpressure: result held with `out_ready=0` for 3 cycles while requesters 1 and 2 are valid -> `req_ready=0`, outputs stable. Raise `out_ready` -> requester 1 is granted the same cycle and its result appears the next cycle.
- Pointer wrap: after a grant to requester 3 with `req_valid=1001` -> next grant goes to requester 0, then requester 3.
- Reset mid-stream: assert `rst_n=0` while FULL -> `out_valid=0` and outputs 0 without waiting for `clk`. After release with `req_valid=1100` -> requester 2 is granted first.
- With `GRAY_CONV_SCHED_CHECK_EN`: force an `out_gray` bit flip via the bench -> `err=1` next cycle, remaining 1 until reset. Normal traffic keeps `err=0`.
